usb_tx_crc16_ctrl: RTL and testbench

Transmit-side sequencer for the USB DATA-packet CRC16 generator. It accepts payload bytes over a valid/ready handshake and serializes each one LSB-first to the downstream bit stage (bit-stuffer/NRZI). It drives the CRC16 generator's clear, shift-enable and data-in controls in lock-step with every transmitted bit. After the last byte it captures the CRC16 value and transmits its one's complement, MSB (crc[15]) first, then signals completion.

---
 rtl/usb_tx_crc16_ctrl.sv | 145 ++++++++++++++
 tb/tb_usb_tx_crc16_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_crc16_ctrl.sv
// Sequences payload bytes LSB-first to the bit stage and drives the CRC16 generator controls,
// then sends the complemented CRC MSB-first. Control outputs decode from the state register.
module usb_tx_crc16_ctrl (
  input  logic        clk,
  input  logic        nRst,
  input  logic        startPkt,
  input  logic        noData,
  input  logic        abort,
  input  logic [7:0]  dataIn,
  input  logic        dataLast,
  input  logic        dataValid,
  output logic        dataReady,
  output logic        bitOut,
  output logic        bitValid,
  input  logic        bitReady,
  output logic        crcClear,
  output logic        crcShiftEn,
  output logic        crcDin,
  input  logic [15:0] crcIn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4,
    S_CRC   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_shreg;
  logic [15:0] r_crcSh;
  logic [2:0]  r_bitCnt;
  logic [3:0]  r_crcCnt;
  logic        r_lastFlag;
  logic        r_noData;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    dataReady  = 1'b0;
    bitOut     = 1'b0;
    bitValid   = 1'b0;
    crcClear   = 1'b0;
    crcShiftEn = 1'b0;
    crcDin     = 1'b0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (startPkt) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        crcClear = 1'b1;
        w_next   = r_noData ? S_LATCH : S_LOAD;
      end
      S_LOAD: begin
        dataReady = 1'b1;
        if (dataValid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        bitValid = 1'b1;
        bitOut   = r_shreg[0];
        // The generator shifts on exactly the cycles the downstream consumes a data bit.
        if (bitReady) begin
          crcShiftEn = 1'b1;
          crcDin     = r_shreg[0];
          if (r_bitCnt == 3'd7) w_next = r_lastFlag ? S_LATCH : S_LOAD;
        end
      end
      S_LATCH: begin
        w_next = S_CRC;
      end
      S_CRC: begin
        bitValid = 1'b1;
        bitOut   = ~r_crcSh[15];
        if (bitReady && (r_crcCnt == 4'd15)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_shreg    <= 8'd0;
      r_crcSh    <= 16'd0;
      r_bitCnt   <= 3'd0;
      r_crcCnt   <= 4'd0;
      r_lastFlag <= 1'b0;
      r_noData   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startPkt) r_noData <= noData;
        end
        S_LOAD: begin
          if (dataValid) begin
            r_shreg    <= dataIn;
            r_lastFlag <= dataLast;
            r_bitCnt   <= 3'd0;
          end
        end
        S_SHIFT: begin
          if (bitReady) begin
            r_shreg  <= {1'b0, r_shreg[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
          end
        end
        S_LATCH: begin
          // crcIn already reflects the final data bit shifted on the previous edge.
          r_crcSh  <= crcIn;
          r_crcCnt <= 4'd0;
        end
        S_CRC: begin
          if (bitReady) begin
            r_crcSh  <= {r_crcSh[14:0], 1'b0};
            r_crcCnt <= r_crcCnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_crc16_ctrl.sv
// Randomized and directed bench for usb_tx_crc16_ctrl with a CRC16 generator model and
// a reference stream built from the byte list (data LSB-first, then ~CRC MSB-first).
module tb_usb_tx_crc16_ctrl;

  logic        clk = 1'b0;
  logic        nRst;
  logic        startPkt, noData, abort;
  logic [7:0]  dataIn;
  logic        dataLast, dataValid, dataReady;
  logic        bitOut, bitValid, bitReady;
  logic        crcClear, crcShiftEn, crcDin;
  logic [15:0] crcIn;
  logic        busy, done;

  usb_tx_crc16_ctrl dut (
    .clk(clk), .nRst(nRst), .startPkt(startPkt), .noData(noData), .abort(abort),
    .dataIn(dataIn), .dataLast(dataLast), .dataValid(dataValid), .dataReady(dataReady),
    .bitOut(bitOut), .bitValid(bitValid), .bitReady(bitReady),
    .crcClear(crcClear), .crcShiftEn(crcShiftEn), .crcDin(crcDin), .crcIn(crcIn),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator: clears to zero, polynomial x^16+x^15+x^2+1, bit-serial.
  always @(posedge clk or negedge nRst) begin
    if (!nRst)           crcIn <= 16'h0000;
    else if (crcClear)   crcIn <= 16'h0000;
    else if (crcShiftEn) crcIn <= {crcIn[14:0], 1'b0} ^ ((crcDin ^ crcIn[15]) ? 16'h8005 : 16'h0000);
  end

  bit obs_bits[$];
  int sh_cnt = 0, sh_ones = 0, clr_cnt = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0, viol = 0;
  bit prev_stall = 1'b0, prev_bit = 1'b0;

  always @(negedge clk) begin
    if (bitValid && bitReady) obs_bits.push_back(bitOut);
    if (crcShiftEn) begin
      sh_cnt++;
      if (crcDin) sh_ones++;
      if (!(bitValid && bitReady && (crcDin == bitOut))) viol++;
    end
    if (crcClear) clr_cnt++;
    if (dataValid && dataReady) hs_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (nRst && prev_stall && !(bitValid && (bitOut == prev_bit))) viol++;
    prev_stall = bitValid && !bitReady && nRst && !abort;
    prev_bit   = bitOut;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input bit msg[$]);
    logic [15:0] r;
    r = 16'h0000;
    foreach (msg[i]) r = (msg[i] ^ r[15]) ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] pack(input int start, input int len);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < len; i++)
      r = {r[30:0], ((start + i) < obs_bits.size()) ? obs_bits[start + i] : 1'b0};
    return r;
  endfunction

  logic [7:0] pkt [0:15];
  int b_bits, b_sh, b_ones, b_clr, b_hs, b_done, b_viol;

  task automatic snap();
    b_bits = obs_bits.size(); b_sh = sh_cnt; b_ones = sh_ones; b_clr = clr_cnt;
    b_hs = hs_cnt; b_done = done_cnt; b_viol = viol;
  endtask

  task automatic drive_data(input int idx, input int n, input bit vrand);
    if (idx < n) begin
      dataIn    = pkt[idx];
      dataLast  = (idx == n - 1);
      dataValid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      dataValid = 1'b0;
      dataLast  = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT idle again.
  task automatic run_pkt(input string name, input int n, input int rmode, input bit vrand);
    bit q[$];
    logic [15:0] c;
    int idx, cnt, t0, mism;
    bit hs;
    snap();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) q.push_back(pkt[i][j]);
    c = crc_ref(q);
    for (int j = 15; j >= 0; j--) q.push_back(~c[j]);
    idx = 0; cnt = 0;
    startPkt = 1'b1; noData = (n == 0); t0 = cyc; bitReady = 1'b1;
    drive_data(idx, n, vrand);
    while (cnt < 4000) begin
      @(negedge clk); #1;
      hs = dataValid && dataReady;
      if (done_cnt != b_done) break;
      @(posedge clk); #1;
      cnt++;
      startPkt = 1'b0;
      if (hs) idx++;
      drive_data(idx, n, vrand);
      case (rmode)
        0:       bitReady = 1'b1;
        1:       bitReady = (cnt % 2) == 1;
        default: bitReady = $urandom_range(0, 2) != 0;
      endcase
    end
    chk({name, "_done_pulses"}, done_cnt - b_done, 1);
    chk({name, "_len"}, obs_bits.size() - b_bits, q.size());
    mism = 0;
    for (int i = 0; i < q.size(); i++)
      if ((b_bits + i >= obs_bits.size()) || (obs_bits[b_bits + i] !== q[i])) mism++;
    chk({name, "_bit_mismatches"}, mism, 0);
    chk({name, "_shift_en"}, sh_cnt - b_sh, 8 * n);
    chk({name, "_clear_pulses"}, clr_cnt - b_clr, 1);
    chk({name, "_handshakes"}, hs_cnt - b_hs, n);
    chk({name, "_protocol_viol"}, viol - b_viol, 0);
    if (rmode == 0 && !vrand) chk({name, "_done_cycle"}, done_cyc - t0, 19 + 9 * n);
    @(posedge clk); #1;
    dataValid = 1'b0; bitReady = 1'b0;
    @(negedge clk); #1;
    chk({name, "_idle_busy"}, {busy, bitValid, done}, 0);
    @(posedge clk); #1;
  endtask

  int n, cnt;
  int s_bits, s_done;

  initial begin
    nRst = 1'b0; startPkt = 0; noData = 0; abort = 0; dataIn = 0;
    dataLast = 0; dataValid = 0; bitReady = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {dataReady, bitOut, bitValid, crcClear, crcShiftEn, crcDin, busy, done}, 0);
    nRst = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_outputs", {dataReady, bitOut, bitValid, crcClear, crcShiftEn, crcDin, busy, done}, 0);
    @(posedge clk); #1;

    // Zero-length packet.
    run_pkt("zero_len", 0, 0, 1'b0);
    chk("zero_len_crc", pack(b_bits, 16), 32'h0000FFFF);

    // Single 0x00 byte.
    pkt[0] = 8'h00;
    run_pkt("byte00", 1, 0, 1'b0);
    chk("byte00_data", pack(b_bits, 8), 32'h0);
    chk("byte00_din_ones", sh_ones - b_ones, 0);
    chk("byte00_crc", pack(b_bits + 8, 16), 32'h0000FFFF);

    // Single 0x01 byte: generator holds 0x8303, complement sent MSB-first.
    pkt[0] = 8'h01;
    run_pkt("byte01", 1, 0, 1'b0);
    chk("byte01_data", pack(b_bits, 8), 32'h00000080);
    chk("byte01_crc", pack(b_bits + 8, 16), 32'h00007CFC);

    // Alternating backpressure across two bytes.
    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    run_pkt("backpressure", 2, 1, 1'b0);
    chk("backpressure_data", pack(b_bits, 16), 32'h0000A53C);

    // Abort while in SHIFT after three consumed bits.
    snap();
    startPkt = 1'b1; noData = 1'b0; dataIn = 8'hC3; dataLast = 1'b1; dataValid = 1'b1; bitReady = 1'b1;
    @(posedge clk); #1;
    startPkt = 1'b0;
    cnt = 0;
    while ((obs_bits.size() - b_bits) < 3 && cnt < 50) begin
      @(negedge clk); #1;
      cnt++;
      if (!dataReady && bitValid) dataValid = 1'b0;
    end
    chk("abort_reached_3_bits", obs_bits.size() - b_bits, 3);
    @(posedge clk); #1;
    bitReady = 1'b0; abort = 1'b1;
    chk("abort_stalled_valid", {bitValid, bitOut}, 2'b10);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outputs_cleared", {dataReady, bitOut, bitValid, crcClear, crcShiftEn, busy, done}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_bits_sent", pack(b_bits, obs_bits.size() - b_bits), 32'h6);
    pkt[0] = 8'h5A; pkt[1] = 8'hF0;
    run_pkt("after_abort", 2, 0, 1'b0);

    // Asynchronous reset in the CRC field.
    snap();
    s_bits = b_bits; s_done = b_done;
    pkt[0] = 8'h96;
    startPkt = 1'b1; noData = 1'b0; dataIn = pkt[0]; dataLast = 1'b1; dataValid = 1'b1; bitReady = 1'b1;
    @(posedge clk); #1;
    startPkt = 1'b0;
    cnt = 0;
    while ((obs_bits.size() - s_bits) < 13 && cnt < 100) begin
      @(negedge clk); #1;
      cnt++;
      if (!dataReady && bitValid) dataValid = 1'b0;
    end
    chk("rst_reached_crc", obs_bits.size() - s_bits, 13);
    #2 nRst = 1'b0;
    #1;
    chk("rst_async_outputs", {dataReady, bitOut, bitValid, crcClear, crcShiftEn, crcDin, busy, done}, 0);
    startPkt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    startPkt = 1'b0; bitReady = 1'b0; dataValid = 1'b0;
    nRst = 1'b1;
    @(negedge clk); #1;
    chk("rst_start_ignored", {busy, crcClear}, 0);
    chk("rst_no_done", done_cnt - s_done, 0);
    @(posedge clk); #1;
    pkt[0] = 8'h12; pkt[1] = 8'h34; pkt[2] = 8'h56;
    run_pkt("after_reset", 3, 0, 1'b0);

    // Randomized packets with random backpressure and valid gaps.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
      run_pkt($sformatf("rand%0d", t), n, (t == 0) ? 0 : 2, t != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
